// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - encodes instruction descriptors into MIPS words and loads them into imem
// Optional checksum output enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_cls,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_resetn,
  output logic              done,
  output logic              full,
  output logic              err
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                cpurst_q, cpurst_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  logic [31:0] enc_word;
  logic        enc_legal;

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_cls)
      5'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      5'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      5'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
      5'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
      5'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100110};
      5'd5:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000000};
      5'd6:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000010};
      5'd7:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000011};
      5'd8:  enc_word = {6'b000000, in_rs, 15'd0, 6'b001000};
      5'd9:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      5'd10: enc_word = {6'b001100, in_rs, in_rt, in_imm};
      5'd11: enc_word = {6'b001101, in_rs, in_rt, in_imm};
      5'd12: enc_word = {6'b001110, in_rs, in_rt, in_imm};
      5'd13: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      5'd14: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      5'd15: enc_word = {6'b000100, in_rs, in_rt, in_imm};
      5'd16: enc_word = {6'b000101, in_rs, in_rt, in_imm};
      5'd17: enc_word = {6'b001111, 5'd0, in_rt, in_imm};
      5'd18: enc_word = {6'b000010, in_target};
      5'd19: enc_word = {6'b000011, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    full_d  = full_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          if (enc_legal) begin
            wdata_d = enc_word;
            last_d  = in_last;
            state_d = S_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ wdata_q;
`endif
        // The counter saturates at the top word instead of wrapping.
        if (last_q || (addr_q == {ADDR_W{1'b1}})) begin
          state_d = S_DONE;
          full_d  = ~last_q;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          full_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 32'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered copies of the next-state decode.
    ready_d  = (state_d == S_IDLE);
    we_d     = (state_d == S_WRITE);
    done_d   = (state_d == S_DONE);
    cpurst_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      last_q   <= 1'b0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      cpurst_q <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      cpurst_q <= cpurst_d;
      done_q   <= done_d;
      full_q   <= full_d;
      err_q    <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_resetn = cpurst_q;
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (small ADDR_W)
// Checksum checks follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int AW   = 2;
  localparam int MAXA = (1 << AW) - 1;

  typedef struct {
    logic [4:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
  } desc_t;

  logic          clock = 1'b0;
  logic          resetn, start, in_valid, in_ready, in_last;
  logic [4:0]    in_cls, in_rs, in_rt, in_rd, in_sa;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          imem_we, cpu_resetn, done, full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  imem_loader #(.ADDR_W(AW)) u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cls     (in_cls),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_sa      (in_sa),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_resetn (cpu_resetn),
    .done       (done),
    .full       (full),
    .err        (err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  int          got_addr[$];
  logic [31:0] got_data[$];

  // Reference model state: expected memory image in write order.
  logic [31:0] m_mem[$];
  int          m_cnt;
  bit          m_done, m_full, m_err;
  logic [31:0] m_csum;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(imem_wdata);
      checks++;
      assert (in_ready === 1'b0) else begin
        failures++;
        $error("FAIL ready_in_write observed=%0b expected=0", in_ready);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(desc_t d);
    int fn[9] = '{32, 34, 36, 37, 38, 0, 2, 3, 8};
    int op[9] = '{8, 12, 13, 14, 35, 43, 4, 5, 15};
    longint unsigned v;
    int c;
    bit shift, jr;
    c = int'(d.cls);
    v = 0;
    if (c <= 8) begin
      shift = (c >= 5) && (c <= 7);
      jr    = (c == 8);
      if (!shift) v += longint'(d.rs) << 21;
      if (!jr)    v += (longint'(d.rt) << 16) + (longint'(d.rd) << 11);
      if (shift)  v += longint'(d.sa) << 6;
      v += longint'(fn[c]);
    end else if (c <= 17) begin
      v = longint'(op[c-9]) << 26;
      if (c != 17) v += longint'(d.rs) << 21;
      v += (longint'(d.rt) << 16) + longint'(d.imm);
    end else begin
      v = (longint'(c - 16) << 26) + longint'(d.tgt);
    end
    return v[31:0];
  endfunction

  function automatic void model_apply(desc_t d);
    logic [31:0] w;
    if (d.cls > 5'd19) begin
      m_err = 1'b1;
    end else begin
      w = enc(d);
      m_mem.push_back(w);
      m_csum ^= w;
      if (d.last || m_cnt == MAXA) begin
        m_done = 1'b1;
        m_full = !d.last;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  function automatic void clear_load();
    m_mem.delete();
    got_addr.delete();
    got_data.delete();
    m_cnt  = 0;
    m_done = 1'b0;
    m_full = 1'b0;
    m_csum = 32'd0;
  endfunction

  function automatic logic [31:0] got(int i);
    if (i < got_data.size()) return got_data[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic desc_t mk(int cls, int rs, int rt, int rd, int sa, int imm, int tgt, bit last);
    desc_t d;
    d.cls = 5'(cls); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.sa = 5'(sa);
    d.imm = 16'(imm); d.tgt = 26'(tgt); d.last = last;
    return d;
  endfunction

  task automatic drive(input desc_t d, input int max_wait, output bit acc);
    int i;
    in_cls = d.cls; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd; in_sa = d.sa;
    in_imm = d.imm; in_target = d.tgt; in_last = d.last;
    in_valid = 1'b1;
    acc = 1'b0;
    i = 0;
    while (!acc && i < max_wait) begin
      if (in_ready === 1'b1) acc = 1'b1;
      else @(negedge clock);
      i++;
    end
    if (acc) begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Accepted exactly when the model says the loader is still loading.
  task automatic send(input desc_t d);
    bit acc, exp_acc;
    exp_acc = !m_done;
    drive(d, exp_acc ? 20 : 4, acc);
    chk("accept", 32'(acc), 32'(exp_acc));
    if (acc) model_apply(d);
  endtask

  task automatic check_load(input string tag);
    int i;
    i = 0;
    while (m_done && done !== 1'b1 && i < 10) begin
      @(negedge clock);
      i++;
    end
    @(negedge clock);
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'(m_done));
    chk({tag, "_full"}, 32'(full), 32'(m_full));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_nwrites"}, 32'(got_data.size()), 32'(m_mem.size()));
    for (int k = 0; k < m_mem.size() && k < got_data.size(); k++) begin
      chk({tag, "_addr"}, 32'(got_addr[k]), 32'(k));
      chk({tag, "_data"}, got_data[k], m_mem[k]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, m_csum);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    clear_load();
    chk("start_done", 32'(done), 32'd0);
    chk("start_cpu_resetn", 32'(cpu_resetn), 32'd0);
    chk("start_full", 32'(full), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_err", 32'(err), 32'(m_err));
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("start_checksum", checksum, 32'd0);
`endif
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    #12;
    clear_load();
    m_err = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'd0);
`endif
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    desc_t d;
    int n;
    resetn = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_cls = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_sa = '0;
    in_imm = '0; in_target = '0;

    apply_reset();

    // single add with last, DONE on the cycle after the write strobe
    send(mk(0, 1, 2, 3, 0, 0, 0, 1'b1));
    chk("t1_we", 32'(imem_we), 32'd1);
    chk("t1_waddr", 32'(imem_addr), 32'd0);
    chk("t1_done_early", 32'(done), 32'd0);
    @(posedge clock);
    #1;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_we_drop", 32'(imem_we), 32'd0);
    check_load("t1");
    chk("t1_word", got(0), 32'h00221820);

    pulse_start();
    send(mk(9, 0, 1, 0, 0, 16'h0005, 0, 1'b0));
    send(mk(13, 1, 2, 0, 0, 16'hFFFC, 0, 1'b1));
    check_load("t2");
    chk("t2_word0", got(0), 32'h20010005);
    chk("t2_word1", got(1), 32'h8C22FFFC);

    pulse_start();
    send(mk(5, 7, 2, 4, 3, 0, 0, 1'b0));
    send(mk(19, 0, 0, 0, 0, 0, 26'h0000010, 1'b1));
    check_load("t3");
    chk("t3_word0", got(0), 32'h000220C0);
    chk("t3_word1", got(1), 32'h0C000010);

    pulse_start();
    send(mk(25, 3, 3, 3, 3, 16'h1234, 26'h1, 1'b1));
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_ready", 32'(in_ready), 32'd1);
    chk("t4_we", 32'(imem_we), 32'd0);
    @(negedge clock);
    chk("t4_nowrite", 32'(got_data.size()), 32'd0);
    send(mk(18, 0, 0, 0, 0, 0, 0, 1'b1));
    check_load("t4");
    chk("t4_word", got(0), 32'h08000000);

    pulse_start();
    for (int k = 0; k < 6; k++)
      send(mk(int'($urandom_range(0, 19)), int'($urandom), int'($urandom), int'($urandom),
              int'($urandom), int'($urandom), int'($urandom), 1'b0));
    check_load("t5");
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_nwrites", 32'(got_data.size()), 32'(MAXA + 1));

    for (int r = 0; r < 10; r++) begin
      pulse_start();
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        d = mk(($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19)),
               int'($urandom), int'($urandom), int'($urandom), int'($urandom),
               int'($urandom), int'($urandom), (k == n - 1));
        send(d);
      end
      if (!m_done) send(mk(int'($urandom_range(0, 19)), 1, 2, 3, 4, 5, 6, 1'b1));
      check_load("rnd");
    end

    // reset while the write strobe is high
    pulse_start();
    send(mk(1, 4, 5, 6, 0, 0, 0, 1'b0));
    chk("t6_we_before", 32'(imem_we), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_cpu_resetn", 32'(cpu_resetn), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t6_checksum", checksum, 32'd0);
`endif
    @(negedge clock);
    @(negedge clock);
    chk("t6_nowrite", 32'(got_data.size()), 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_ready_after", 32'(in_ready), 32'd1);
    chk("t6_err_cleared", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Encoder counterpart to the pipeline's control-unit instruction decode.
- Accepts instruction descriptors (class plus fields) over a valid/ready handshake and encodes each into a 32-bit MIPS word.
- Writes the words sequentially into instruction memory starting at word address 0.
- Holds the CPU in reset until loading completes. Used for boot and for bench program loading.

Parameters:
ADDR_W, 6, instruction-memory word-address width (depth 2^ADDR_W words)

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  pulse; restarts a load from DONE
in_valid  in  1  descriptor valid
in_ready  out  1  loader can accept descriptor
in_cls  in  5  instruction class code (see Behaviour)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_sa  in  5  shamt field
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target field
in_last  in  1  this descriptor is the final one
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
cpu_resetn  out  1  low holds the CPU in reset
done  out  1  load complete
full  out  1  load ended by address exhaustion
err  out  1  sticky: illegal class seen

Behaviour:
- Reset is asynchronous and active-low. Asserting resetn low forces:
  - state IDLE, addr counter 0
  - imem_we 0, imem_wdata 0, imem_addr 0
  - in_ready 0 during reset, 1 the first cycle after release
  - cpu_resetn 0, done 0, full 0, err 0
- Reset mid-load aborts immediately. Words already written stay in memory; no further writes occur.
- Class codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui, 18 j, 19 jal. Codes 20-31 are illegal.
- R-type words: op=000000, then rs|rt|rd|sa|func.
  - func: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
  - Shifts force rs=0.
  - jr forces rt=rd=sa=0.
  - Non-shift R-types force sa=0.
- I-type words: op|rs|rt|imm.
  - op: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111.
  - lui forces rs=0.
  - imm is passed raw; no extension in the encoder.
- J-type words: op|target. op: j 000010, jal 000011.
- Unused descriptor fields are ignored.
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid & in_ready. On accept, the encoded word is registered into imem_wdata and the state moves to WRITE.
  - If in_cls is illegal: no write, err set (sticky until reset), state stays IDLE, and in_last is ignored.
- WRITE:
  - in_ready=0. imem_we=1 for exactly one cycle, with imem_addr equal to the current counter.
  - Latency: accept at edge N, write strobe during cycle N+1, so throughput is one word per 2 cycles.
  - Next state:
    - If in_last, or the counter equals 2^ADDR_W-1: go to DONE. full=1 only in the exhaustion case without in_last.
    - Otherwise: counter+1, go to IDLE.
  - The counter never wraps.
- DONE:
  - in_ready=0, done=1, cpu_resetn=1. in_valid is ignored.
  - A start pulse returns to IDLE: counter 0, done 0, full 0, cpu_resetn 0. err is preserved.
- start outside DONE is ignored.
- imem_wdata holds its last value when imem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], the XOR of every word written since reset or start.
  - Updated on the same edge that ends each WRITE cycle.
  - Reset value 0; cleared on start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset release, then add rs=1 rt=2 rd=3 with in_last=1 -> one write at addr 0 of 0x00221820; DONE next cycle; done=1, cpu_resetn=1.
- Stream addi rs=0 rt=1 imm=0x0005, then lw rs=1 rt=2 imm=0xFFFC (last) -> addr0=0x20010005, addr1=0x8C22FFFC; in_ready low during each WRITE cycle.
- sll rt=2 rd=4 sa=3 with in_rs=7, then jal target=0x0000010 -> 0x000220C0 (rs forced 0), then 0x0C000010.
- in_cls=25 in IDLE -> no imem_we, err=1, in_ready stays 1; a following j target=0 is written at addr 0 as 0x08000000.
- ADDR_W=2, stream 6 legal descriptors with no in_last -> exactly 4 writes at addr 0..3, then DONE with full=1; remaining descriptors not accepted.
- resetn low during a WRITE cycle -> imem_we drops immediately, cpu_resetn=0, counter 0; with the checksum macro defined, checksum=0; start in DONE clears checksum.
